// File: rtl/reflet_gpu_pkg.sv
// Shared definitions for the reflet GPU blocks: fill FSM state encoding and
// the default screen/colour widths also used by reflet_VGA.
package reflet_gpu_pkg;

  localparam int DEF_COLOR_DEPTH = 2;
  localparam int DEF_H_BITS      = 7;
  localparam int DEF_V_BITS      = 6;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } fill_state_e;

endpackage

// File: rtl/reflet_rect_scan.sv
// 2D raster cursor for the rectangle filler. Cursor runs at one extra bit of
// width so the end points never overflow; the visible coordinate is the low
// bits, which gives wrap-around for free.
// Build option: REFLET_RECT_CLIP_EN clamps the end points to the screen edge.
module reflet_rect_scan
  import reflet_gpu_pkg::*;
#(
  parameter int h_bits = DEF_H_BITS,
  parameter int v_bits = DEF_V_BITS
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              step,
  input  logic [h_bits-1:0] x0,
  input  logic [v_bits-1:0] y0,
  input  logic [h_bits-1:0] w_m1,
  input  logic [v_bits-1:0] h_m1,
  output logic [h_bits-1:0] x,
  output logic [v_bits-1:0] y,
  output logic [h_bits-1:0] x_nxt,
  output logic [v_bits-1:0] y_nxt,
  output logic              last
);

  logic [h_bits:0] x_q, xe_q, x_sum, x_end, x_nxt_e;
  logic [v_bits:0] y_q, ye_q, y_sum, y_end, y_nxt_e;
  logic [h_bits-1:0] x0_q;
  logic row_end;

  assign x_sum = {1'b0, x0} + {1'b0, w_m1};
  assign y_sum = {1'b0, y0} + {1'b0, h_m1};

`ifdef REFLET_RECT_CLIP_EN
  // x0/y0 are always on screen, so clamping the end keeps at least one pixel.
  localparam logic [h_bits:0] XMAX = {1'b0, {h_bits{1'b1}}};
  localparam logic [v_bits:0] YMAX = {1'b0, {v_bits{1'b1}}};
  assign x_end = (x_sum > XMAX) ? XMAX : x_sum;
  assign y_end = (y_sum > YMAX) ? YMAX : y_sum;
`else
  assign x_end = x_sum;
  assign y_end = y_sum;
`endif

  // Next cursor position: x first, then return to x0 and move down a row.
  always_comb begin
    row_end = (x_q == xe_q);
    x_nxt_e = row_end ? {1'b0, x0_q} : x_q + 1'b1;
    y_nxt_e = row_end ? y_q + 1'b1 : y_q;
  end

  assign last  = row_end && (y_q == ye_q);
  assign x     = x_q[h_bits-1:0];
  assign y     = y_q[v_bits-1:0];
  assign x_nxt = x_nxt_e[h_bits-1:0];
  assign y_nxt = y_nxt_e[v_bits-1:0];

  // Cursor and bound registers: captured on load, advanced on step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q  <= '0;
      y_q  <= '0;
      xe_q <= '0;
      ye_q <= '0;
      x0_q <= '0;
    end else if (load) begin
      x_q  <= {1'b0, x0};
      y_q  <= {1'b0, y0};
      xe_q <= x_end;
      ye_q <= y_end;
      x0_q <= x0;
    end else if (step) begin
      x_q <= x_nxt_e;
      y_q <= y_nxt_e;
    end
  end

endmodule

// File: rtl/reflet_vga_rect_fill.sv
// Command-driven rectangle filler feeding the reflet_VGA pixel write port.
// One command in, one write per pixel out in raster order, one write every
// write_period cycles, then a one-cycle done pulse.
// Build option: REFLET_RECT_CLIP_EN (see reflet_rect_scan) clips to screen;
// default build wraps coordinates.
module reflet_vga_rect_fill
  import reflet_gpu_pkg::*;
#(
  parameter int color_depth  = DEF_COLOR_DEPTH,
  parameter int h_bits       = DEF_H_BITS,
  parameter int v_bits       = DEF_V_BITS,
  parameter int write_period = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [h_bits-1:0]      x0,
  input  logic [v_bits-1:0]      y0,
  input  logic [h_bits-1:0]      w_m1,
  input  logic [v_bits-1:0]      h_m1,
  input  logic [color_depth-1:0] R_in,
  input  logic [color_depth-1:0] G_in,
  input  logic [color_depth-1:0] B_in,
  output logic                   busy,
  output logic                   done,
  output logic                   write_en,
  output logic [h_bits-1:0]      h_pixel,
  output logic [v_bits-1:0]      v_pixel,
  output logic [color_depth-1:0] R_out,
  output logic [color_depth-1:0] G_out,
  output logic [color_depth-1:0] B_out
);

  // WAIT lasts write_period-1 cycles: load period-2 and leave on zero.
  localparam int CW = (write_period > 1) ? $clog2(write_period) : 1;
  localparam logic [CW-1:0] WAIT_LOAD = CW'((write_period > 1) ? write_period - 2 : 0);

  fill_state_e state;
  logic [CW-1:0] wait_cnt;

  logic              scan_load, scan_step, scan_last;
  logic [h_bits-1:0] scan_x, scan_x_nxt;
  logic [v_bits-1:0] scan_y, scan_y_nxt;

  assign cmd_ready = (state == ST_IDLE);
  assign busy      = (state != ST_IDLE);
  assign scan_load = (state == ST_IDLE) && cmd_valid;
  assign scan_step = (state == ST_WRITE) && !scan_last;

  reflet_rect_scan #(.h_bits(h_bits), .v_bits(v_bits)) u_scan (
    .clk   (clk),
    .rst_n (reset),
    .load  (scan_load),
    .step  (scan_step),
    .x0    (x0),
    .y0    (y0),
    .w_m1  (w_m1),
    .h_m1  (h_m1),
    .x     (scan_x),
    .y     (scan_y),
    .x_nxt (scan_x_nxt),
    .y_nxt (scan_y_nxt),
    .last  (scan_last)
  );

  // Fill FSM; write strobe and coordinates are registered on entry to WRITE.
  // Colour outputs double as the latched fill colour.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= ST_IDLE;
      wait_cnt <= '0;
      done     <= 1'b0;
      write_en <= 1'b0;
      h_pixel  <= '0;
      v_pixel  <= '0;
      R_out    <= '0;
      G_out    <= '0;
      B_out    <= '0;
    end else begin
      write_en <= 1'b0;
      done     <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            state    <= ST_WRITE;
            write_en <= 1'b1;
            h_pixel  <= x0;
            v_pixel  <= y0;
            R_out    <= R_in;
            G_out    <= G_in;
            B_out    <= B_in;
          end
        end
        ST_WRITE: begin
          if (scan_last) begin
            state <= ST_DONE;
            done  <= 1'b1;
          end else if (write_period > 1) begin
            state    <= ST_WAIT;
            wait_cnt <= WAIT_LOAD;
          end else begin
            write_en <= 1'b1;
            h_pixel  <= scan_x_nxt;
            v_pixel  <= scan_y_nxt;
          end
        end
        ST_WAIT: begin
          if (wait_cnt == '0) begin
            state    <= ST_WRITE;
            write_en <= 1'b1;
            h_pixel  <= scan_x;
            v_pixel  <= scan_y;
          end else begin
            wait_cnt <= wait_cnt - CW'(1);
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_reflet_vga_rect_fill.sv
// Bench for reflet_vga_rect_fill: two instances (write periods 1 and 64)
// fed the same commands; each write is checked against a pixel list built
// from plain nested loops over the rectangle.
module tb_reflet_vga_rect_fill;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic [6:0] x0_i = '0, w_i = '0;
  logic [5:0] y0_i = '0, h_i = '0;
  logic [1:0] r_i = '0, g_i = '0, b_i = '0;

  logic       rdy[2], bsy[2], dn[2], we[2];
  logic [6:0] hp[2];
  logic [5:0] vp[2];
  logic [1:0] ro[2], go[2], bo[2];

  int per[2] = '{1, 64};
  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  reflet_vga_rect_fill #(.color_depth(2), .h_bits(7), .v_bits(6), .write_period(1)) u_p1 (
    .clk(clk), .reset(rst_n), .cmd_valid(cmd_valid), .cmd_ready(rdy[0]),
    .x0(x0_i), .y0(y0_i), .w_m1(w_i), .h_m1(h_i), .R_in(r_i), .G_in(g_i), .B_in(b_i),
    .busy(bsy[0]), .done(dn[0]), .write_en(we[0]), .h_pixel(hp[0]), .v_pixel(vp[0]),
    .R_out(ro[0]), .G_out(go[0]), .B_out(bo[0]));

  reflet_vga_rect_fill #(.color_depth(2), .h_bits(7), .v_bits(6), .write_period(64)) u_p64 (
    .clk(clk), .reset(rst_n), .cmd_valid(cmd_valid), .cmd_ready(rdy[1]),
    .x0(x0_i), .y0(y0_i), .w_m1(w_i), .h_m1(h_i), .R_in(r_i), .G_in(g_i), .B_in(b_i),
    .busy(bsy[1]), .done(dn[1]), .write_en(we[1]), .h_pixel(hp[1]), .v_pixel(vp[1]),
    .R_out(ro[1]), .G_out(go[1]), .B_out(bo[1]));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Issue one command, then watch both instances until each has pulsed done
  // and returned to idle. Inputs are scrambled right after acceptance.
  task automatic run_fill(input int x, input int y, input int w, input int h,
                          input logic [1:0] r, input logic [1:0] g, input logic [1:0] b,
                          input bit hold_req);
    int ex[$];
    int ey[$];
    int idx[2] = '{0, 0};
    int lastw[2] = '{0, 0};
    int stage[2] = '{0, 0};
    int budget;
    bit hold;
    for (int dy = 0; dy <= h; dy++) begin
      for (int dx = 0; dx <= w; dx++) begin
        int xx = x + dx;
        int yy = y + dy;
`ifdef REFLET_RECT_CLIP_EN
        if (xx > 127 || yy > 63) continue;
`else
        xx = xx % 128;
        yy = yy % 64;
`endif
        ex.push_back(xx);
        ey.push_back(yy);
      end
    end
    hold = hold_req && (ex.size() >= 4);
    budget = ex.size() * 64 + 10;

    x0_i = 7'(x); y0_i = 6'(y); w_i = 7'(w); h_i = 6'(h);
    r_i = r; g_i = g; b_i = b;
    cmd_valid = 1'b1;
    for (int k = 0; k < 2; k++) chk("ready_before", {31'd0, rdy[k]}, 1);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    x0_i = 7'($urandom); y0_i = 6'($urandom); w_i = 7'($urandom); h_i = 6'($urandom);
    r_i = ~r; g_i = ~g; b_i = ~b;

    for (int cyc = 1; cyc <= budget && (stage[0] != 2 || stage[1] != 2); cyc++) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        if (stage[k] == 0) begin
          chk("busy_not_ready", {30'd0, bsy[k], rdy[k]}, 32'd2);
          if (we[k]) begin
            if (idx[k] == 0) chk("first_write_latency", cyc, 1);
            else chk("write_gap", cyc - lastw[k], per[k]);
            if (idx[k] < ex.size()) begin
              chk("pixel_xy", {19'd0, hp[k], vp[k]}, (ex[idx[k]] << 6) | ey[idx[k]]);
              chk("pixel_rgb", {26'd0, ro[k], go[k], bo[k]}, {26'd0, r, g, b});
            end else begin
              chk("extra_write", 1, 0);
            end
            idx[k]++;
            lastw[k] = cyc;
          end
          if (dn[k]) begin
            chk("write_count", idx[k], ex.size());
            chk("done_latency", cyc, lastw[k] + 1);
            stage[k] = 1;
          end
        end else if (stage[k] == 1) begin
          chk("back_to_idle", {28'd0, rdy[k], bsy[k], dn[k], we[k]}, 32'd8);
          stage[k] = 2;
        end
      end
      if (hold && cyc < 4) begin
        cmd_valid = 1'b1;
        x0_i = 7'($urandom); y0_i = 6'($urandom);
      end else begin
        cmd_valid = 1'b0;
      end
    end
    cmd_valid = 1'b0;
    if (stage[0] != 2 || stage[1] != 2) chk("fill_timeout", 0, 1);
  endtask

  task automatic reset_mid_fill();
    x0_i = 7'd20; y0_i = 6'd10; w_i = 7'd5; h_i = 6'd2;
    r_i = 2'd3; g_i = 2'd2; b_i = 2'd1;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      chk("reset_outputs", {11'd0, we[k], dn[k], hp[k], vp[k], ro[k], go[k], bo[k]}, 0);
      chk("reset_ready", {30'd0, rdy[k], bsy[k]}, 32'd2);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    for (int k = 0; k < 2; k++) chk("no_done_after_reset", {31'd0, dn[k]}, 0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk("reset_state", {11'd0, we[k], dn[k], hp[k], vp[k], ro[k], go[k], bo[k]}, 0);
      chk("reset_ready", {30'd0, rdy[k], bsy[k]}, 32'd2);
    end
    rst_n = 1'b1;
    @(negedge clk);

    run_fill(5, 3, 2, 1, 2'd1, 2'd2, 2'd3, 1'b0);
    run_fill(40, 20, 0, 0, 2'b10, 2'b01, 2'b00, 1'b0);
    run_fill(0, 0, 1, 1, 2'd3, 2'd0, 2'd1, 1'b0);
    run_fill(126, 0, 3, 0, 2'd1, 2'd1, 2'd1, 1'b0);
    run_fill(120, 62, 9, 2, 2'd2, 2'd3, 2'd0, 1'b0);
    run_fill(10, 10, 3, 1, 2'd0, 2'd3, 2'd2, 1'b1);
    reset_mid_fill();
    run_fill(60, 30, 2, 2, 2'd3, 2'd3, 2'd3, 1'b0);

    for (int t = 0; t < 12; t++) begin
      run_fill($urandom_range(0, 127), $urandom_range(0, 63),
               $urandom_range(0, 5), $urandom_range(0, 2),
               2'($urandom), 2'($urandom), 2'($urandom), 1'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
